// File: rtl/sht40_pkg.sv
// Shared types and constants for the SHT40 I2C target emulation.
package sht40_pkg;

   localparam logic [6:0] DEF_TARGET_ADDR = 7'h44;
   localparam logic [7:0] DEF_CMD_MEASURE = 8'hFD;
   localparam logic [7:0] CRC_POLY        = 8'h31;
   localparam logic [7:0] CRC_INIT        = 8'hFF;
   localparam int         FRAME_BYTES     = 6;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      ADDR     = 4'd1,
      ADDR_ACK = 4'd2,
      CMD      = 4'd3,
      CMD_ACK  = 4'd4,
      TX       = 4'd5,
      TX_ACK   = 4'd6,
      IGNORE   = 4'd7
   } state_t;

   typedef struct packed {
      logic [15:0] temp;
      logic [7:0]  temp_crc;
      logic [15:0] hum;
      logic [7:0]  hum_crc;
   } frame_t;

   function automatic logic [7:0] frame_byte(input frame_t f, input logic [2:0] i);
      case (i)
         3'd0:    return f.temp[15:8];
         3'd1:    return f.temp[7:0];
         3'd2:    return f.temp_crc;
         3'd3:    return f.hum[15:8];
         3'd4:    return f.hum[7:0];
         default: return f.hum_crc;
      endcase
   endfunction

endpackage

// File: rtl/sht_crc8.sv
// Sensirion CRC-8 over one 16-bit word: poly 0x31, init 0xFF, MSB-first, no final XOR.
module sht_crc8
   import sht40_pkg::*;
(
   input  logic [15:0] data,
   output logic [7:0]  crc
);

   always_comb begin
      logic [7:0] c;
      logic       fb;
      c  = CRC_INIT;
      fb = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         fb = c[7] ^ data[i];
         c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
      end
      crc = c;
   end

endmodule

// File: rtl/sht40_target.sv
// I2C target emulating an SHT40: accepts the measure command, then serves a
// 6-byte {temp, crc, hum, crc} frame on reads once the measurement delay expires.
module sht40_target
   import sht40_pkg::*;
#(
   parameter logic [6:0]  TARGET_ADDR = DEF_TARGET_ADDR,
   parameter logic [7:0]  CMD_MEASURE = DEF_CMD_MEASURE,
   parameter int unsigned MEAS_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [15:0] temp_word,
   input  logic [15:0] hum_word,
   output logic        cmd_strobe,
   output logic        busy,
   output logic [3:0]  state_out
);

   localparam int CNT_W = (MEAS_CYCLES < 2) ? 1 : $clog2(MEAS_CYCLES + 1);

   logic scl_s1, scl_s2, scl_d;
   logic sda_s1, sda_s2, sda_d;

   // Sync flops reset high so an idle bus produces no spurious edges.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         {scl_s1, scl_s2, scl_d} <= 3'b111;
         {sda_s1, sda_s2, sda_d} <= 3'b111;
      end else begin
         {scl_s1, scl_s2, scl_d} <= {scl_in, scl_s1, scl_s2};
         {sda_s1, sda_s2, sda_d} <= {sda_in, sda_s1, sda_s2};
      end
   end

   logic scl_rise, scl_fall, start_c, stop_c;
   assign scl_rise = scl_s2 & ~scl_d;
   assign scl_fall = ~scl_s2 & scl_d;
   assign start_c  = scl_s2 & scl_d & sda_d & ~sda_s2;
   assign stop_c   = scl_s2 & scl_d & ~sda_d & sda_s2;

   logic [7:0] temp_crc, hum_crc;
   sht_crc8 u_crc_temp (.data(temp_word), .crc(temp_crc));
   sht_crc8 u_crc_hum  (.data(hum_word),  .crc(hum_crc));

   state_t     state;
   logic [3:0] bit_cnt;
   logic [7:0] shift;
   logic [2:0] idx;
   logic [7:0] tx_byte;
   frame_t     frame;
   logic       data_valid;
   logic [CNT_W-1:0] busy_cnt;
   logic       addr_ok;

   assign busy      = (busy_cnt != '0);
   assign state_out = state;
   // Reads are only accepted once a frame exists and the measurement delay is over.
   assign addr_ok   = (shift[7:1] == TARGET_ADDR) && (!shift[0] || (data_valid && !busy));

   always_ff @(posedge clk) begin
      if (!rst_n)
         busy_cnt <= '0;
      else if (cmd_strobe)
         busy_cnt <= CNT_W'(MEAS_CYCLES);
      else if (busy_cnt != '0)
         busy_cnt <= busy_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         sda_oe     <= 1'b0;
         cmd_strobe <= 1'b0;
         bit_cnt    <= '0;
         shift      <= '0;
         idx        <= '0;
         tx_byte    <= '0;
         frame      <= '0;
         data_valid <= 1'b0;
      end else begin
         cmd_strobe <= 1'b0;
         if (start_c) begin
            state   <= ADDR;
            bit_cnt <= '0;
            idx     <= '0;
            sda_oe  <= 1'b0;
         end else if (stop_c) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
         end else begin
            case (state)
               ADDR, CMD: begin
                  if (scl_rise) begin
                     shift   <= {shift[6:0], sda_s2};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     if (state == ADDR) begin
                        if (addr_ok) begin
                           sda_oe <= 1'b1;
                           state  <= ADDR_ACK;
                        end else begin
                           state <= IGNORE;
                        end
                     end else if (shift == CMD_MEASURE) begin
                        sda_oe     <= 1'b1;
                        frame      <= {temp_word, temp_crc, hum_word, hum_crc};
                        data_valid <= 1'b1;
                        cmd_strobe <= 1'b1;
                        state      <= CMD_ACK;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     bit_cnt <= '0;
                     if (shift[0]) begin
                        // Falling edge ending the ACK also presents the first data bit.
                        state   <= TX;
                        idx     <= '0;
                        tx_byte <= frame_byte(frame, 3'd0);
                        sda_oe  <= ~frame.temp[15];
                     end else begin
                        state  <= CMD;
                        sda_oe <= 1'b0;
                     end
                  end
               end
               CMD_ACK: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= IGNORE;
                  end
               end
               TX: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe <= 1'b0;
                        state  <= TX_ACK;
                     end else begin
                        sda_oe <= ~tx_byte[3'd7 - bit_cnt[2:0]];
                     end
                  end
               end
               TX_ACK: begin
                  if (scl_rise) begin
                     if (!sda_s2) begin
                        bit_cnt <= '0;
                        state   <= TX;
                        if (idx < 3'(FRAME_BYTES - 1)) begin
                           idx     <= idx + 3'd1;
                           tx_byte <= frame_byte(frame, idx + 3'd1);
                        end else begin
                           tx_byte <= 8'hFF;
                        end
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               IDLE, IGNORE: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sht40_target.sv
// Directed bench for sht40_target: bit-banged I2C master with hand-computed expectations.
module tb_sht40_target;

   localparam int MEAS = 300;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl = 1'b1;
   logic        sda_m = 1'b1;
   logic        sda_line;
   logic        sda_oe, cmd_strobe, busy;
   logic [3:0]  state_out;
   logic [15:0] temp_word, hum_word;

   int checks = 0;
   int failures = 0;
   int strobes = 0;
   logic mon_en = 1'b0;
   logic oe_glitch = 1'b0;
   logic oe_q = 1'b0;
   logic scl_q = 1'b1;

   assign sda_line = sda_m & ~sda_oe;

   sht40_target #(.TARGET_ADDR(7'h44), .CMD_MEASURE(8'hFD), .MEAS_CYCLES(MEAS)) dut (
      .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
      .temp_word(temp_word), .hum_word(hum_word), .cmd_strobe(cmd_strobe),
      .busy(busy), .state_out(state_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      oe_q  <= sda_oe;
      scl_q <= scl;
      if (cmd_strobe === 1'b1) strobes <= strobes + 1;
      if (mon_en && oe_q !== sda_oe && scl && scl_q) oe_glitch <= 1'b1;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      wait_clk(5); sda_m = 1'b1;
      wait_clk(5); scl = 1'b1;
      wait_clk(5); sda_m = 1'b0;
      wait_clk(5); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(5); sda_m = 1'b0;
      wait_clk(5); scl = 1'b1;
      wait_clk(5); sda_m = 1'b1;
      wait_clk(10);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         wait_clk(5); sda_m = b[i];
         wait_clk(5); scl = 1'b1;
         wait_clk(10); scl = 1'b0;
      end
      wait_clk(5); sda_m = 1'b1;
      wait_clk(5); scl = 1'b1;
      wait_clk(5); ack = ~sda_line;
      wait_clk(5); scl = 1'b0;
   endtask

   task automatic read_bits(input int n, output logic [7:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         wait_clk(5); sda_m = 1'b1;
         wait_clk(5); scl = 1'b1;
         wait_clk(5); v = {v[6:0], sda_line};
         wait_clk(5); scl = 1'b0;
      end
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] v);
      read_bits(8, v);
      wait_clk(5); sda_m = ~ack;
      wait_clk(5); scl = 1'b1;
      wait_clk(10); scl = 1'b0;
   endtask

   initial begin
      logic       ack;
      logic [7:0] v;
      int         n;
      logic [7:0] exp_frame [6];
      exp_frame = '{8'hBE, 8'hEF, 8'h92, 8'hAB, 8'hCD, 8'h6F};
      temp_word = 16'hBEEF;
      hum_word  = 16'hABCD;

      wait_clk(3);
      chk("rst_state", 16'(state_out), 16'd0);
      chk("rst_sda_oe", 16'(sda_oe), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_strobe", 16'(cmd_strobe), 16'd0);
      rst_n = 1'b1;
      wait_clk(5);
      mon_en = 1'b1;

      // read with no prior command
      i2c_start(); write_byte(8'h89, ack);
      chk("nocmd_rd_ack", 16'(ack), 16'd0);
      chk("nocmd_rd_state", 16'(state_out), 16'd7);
      i2c_stop(); wait_clk(3);
      chk("stop_idle", 16'(state_out), 16'd0);

      // measure command
      i2c_start(); write_byte(8'h88, ack);
      chk("wr_addr_ack", 16'(ack), 16'd1);
      write_byte(8'hFD, ack);
      chk("cmd_ack", 16'(ack), 16'd1);
      chk("busy_after_cmd", 16'(busy), 16'd1);
      chk("strobe_once", 16'(strobes), 16'd1);
      i2c_stop();
      temp_word = 16'h1234;
      hum_word  = 16'h5678;

      // read while busy
      i2c_start(); write_byte(8'h89, ack);
      chk("busy_rd_ack", 16'(ack), 16'd0);
      chk("busy_rd_oe", 16'(sda_oe), 16'd0);
      chk("busy_still", 16'(busy), 16'd1);
      i2c_stop();

      n = 0;
      while (busy === 1'b1 && n < 2000) begin wait_clk(1); n++; end
      chk("busy_falls", 16'(busy), 16'd0);

      // full frame read
      i2c_start(); write_byte(8'h89, ack);
      chk("rd_addr_ack", 16'(ack), 16'd1);
      for (int i = 0; i < 6; i++) begin
         read_byte(i < 5, v);
         chk($sformatf("frame_b%0d", i), 16'(v), 16'(exp_frame[i]));
      end
      i2c_stop();

      // wrong address, wrong command
      i2c_start(); write_byte(8'h8A, ack);
      chk("bad_addr_nack", 16'(ack), 16'd0);
      i2c_stop();
      i2c_start(); write_byte(8'h88, ack);
      chk("wr2_addr_ack", 16'(ack), 16'd1);
      write_byte(8'h24, ack);
      chk("bad_cmd_nack", 16'(ack), 16'd0);
      chk("bad_cmd_state", 16'(state_out), 16'd7);
      i2c_stop();
      chk("no_extra_strobe", 16'(strobes), 16'd1);

      // repeated START inside byte 2
      i2c_start(); write_byte(8'h89, ack);
      chk("rs_addr_ack", 16'(ack), 16'd1);
      read_byte(1'b1, v); chk("rs_b0", 16'(v), 16'h00BE);
      read_byte(1'b1, v); chk("rs_b1", 16'(v), 16'h00EF);
      read_bits(3, v);    chk("rs_b2_part", 16'(v), 16'h0004);
      i2c_start(); write_byte(8'h89, ack);
      chk("rs_readdr_ack", 16'(ack), 16'd1);
      read_byte(1'b0, v); chk("rs_restart_b0", 16'(v), 16'h00BE);
      i2c_stop();

      // reset while the target drives a 0 data bit (bit 6 of 0xBE)
      i2c_start(); write_byte(8'h89, ack);
      read_bits(1, v);
      wait_clk(6);
      chk("drive_zero", 16'(sda_oe), 16'd1);
      rst_n = 1'b0;
      wait_clk(1);
      chk("rst_mid_oe", 16'(sda_oe), 16'd0);
      chk("rst_mid_state", 16'(state_out), 16'd0);
      wait_clk(2);
      rst_n = 1'b1;
      sda_m = 1'b1; scl = 1'b1;
      wait_clk(10);
      i2c_start(); write_byte(8'h89, ack);
      chk("post_rst_rd_nack", 16'(ack), 16'd0);
      i2c_stop();

      chk("oe_stable_scl_high", 16'(oe_glitch), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
